// File: rtl/ldpc_ram_read_scheduler.sv
// ldpc_ram_read_scheduler: walks column -> branch -> address over an LDPC RAM bank, issuing one-hot read requests.
module ldpc_ram_read_scheduler #(
  parameter int WIDTH_BR = 4,
  parameter int NUM_RAMS = 12,
  parameter int MAX_BRANCHES = 8,
  parameter int EXPANSION_FACTOR = 96,
  parameter logic [WIDTH_BR*NUM_RAMS-1:0] BRANCH_CFG = {NUM_RAMS{4'd6}},
  localparam int AW = $clog2(EXPANSION_FACTOR),
  localparam int RW = NUM_RAMS > 1 ? $clog2(NUM_RAMS) : 1,
  localparam int BW = MAX_BRANCHES > 1 ? $clog2(MAX_BRANCHES) : 1,
  localparam int VW = MAX_BRANCHES * NUM_RAMS,
  localparam int SW = VW > 1 ? $clog2(VW) : 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_start,
  output logic          o_start_ready,
  input  logic          i_abort,
  output logic [AW-1:0] o_addr,
  output logic [VW-1:0] o_addr_valid,
  input  logic [VW-1:0] i_addr_ready,
  output logic [RW-1:0] o_ram_idx,
  output logic [BW-1:0] o_branch_idx,
  output logic          o_last,
  output logic          o_busy,
  output logic          o_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, SKIP, DONE} state_t;
  function automatic int cnt(input int r);
    if (r >= NUM_RAMS) return 0;
    return int'(BRANCH_CFG[r*WIDTH_BR +: WIDTH_BR]);
  endfunction
  if (EXPANSION_FACTOR < 2) begin : g_bad_z
    $error("EXPANSION_FACTOR must be at least 2");
  end
  for (genvar i = 0; i < NUM_RAMS; i++) begin : g_chk
    if (cnt(i) > MAX_BRANCHES) begin : g_bad
      $error("BRANCH_CFG entry exceeds MAX_BRANCHES");
    end
  end
  state_t state, state_n, col_next;
  logic [AW-1:0] a, a_n;
  logic [BW-1:0] b, b_n;
  logic [RW-1:0] r, r_n;
  logic [SW-1:0] sel;
  logic xfer, last_col, br_end, a_end;
  always_comb begin
    sel = SW'(int'(b) * NUM_RAMS + int'(r));
    xfer = state == ISSUE && i_addr_ready[sel];
    last_col = int'(r) == NUM_RAMS - 1;
    br_end = int'(b) == cnt(int'(r)) - 1;
    a_end = int'(a) == EXPANSION_FACTOR - 1;
    col_next = last_col ? DONE : (cnt(int'(r) + 1) != 0 ? ISSUE : SKIP);
    state_n = state;
    a_n = a;
    b_n = b;
    r_n = r;
    case (state)
      IDLE: if (i_start) begin
        a_n = '0;
        b_n = '0;
        r_n = '0;
        state_n = cnt(0) != 0 ? ISSUE : SKIP;
      end
      ISSUE: if (xfer) begin
        a_n = a_end ? '0 : a + AW'(1);
        b_n = !a_end ? b : (br_end ? '0 : b + BW'(1));
        r_n = !(a_end && br_end) ? r : (last_col ? '0 : r + RW'(1));
        state_n = a_end && br_end ? col_next : ISSUE;
      end
      SKIP: begin
        r_n = last_col ? '0 : r + RW'(1);
        state_n = col_next;
      end
      default: state_n = IDLE;
    endcase
    // abort clears everything and suppresses the done pulse
    if (i_abort && state != IDLE) begin
      state_n = IDLE;
      a_n = '0;
      b_n = '0;
      r_n = '0;
    end
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      r <= '0;
    end else begin
      state <= state_n;
      a <= a_n;
      b <= b_n;
      r <= r_n;
    end
  end
  assign o_start_ready = state == IDLE;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  assign o_addr = a;
  assign o_ram_idx = r;
  assign o_branch_idx = b;
  assign o_addr_valid = state == ISSUE ? VW'(1) << sel : '0;
  assign o_last = state == ISSUE && last_col && br_end && a_end;
endmodule

// File: tb/tb_ldpc_ram_read_scheduler.sv
// tb_ldpc_ram_read_scheduler: randomized frame checks against an expected address-sequence model.
module tb_ldpc_ram_read_scheduler;
  localparam int NR = 3;
  localparam int Z = 4;
  localparam int VW = 6;
  typedef struct {bit skip; int r; int b; int a; bit last;} ent_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [VW-1:0] ready = '0;
  logic start_ready, last, busy, done;
  logic [1:0] addr, ram_idx;
  logic [0:0] br_idx;
  logic [VW-1:0] valid;
  logic z_start = 0, z_abort = 0, z_sr, z_last, z_busy, z_done;
  logic [3:0] z_ready = '1;
  logic [3:0] z_valid;
  logic [1:0] z_addr;
  logic [0:0] z_ri, z_bi;
  int checks = 0, failures = 0;
  int cfg[NR] = '{2, 0, 1};
  ent_t q[$];

  ldpc_ram_read_scheduler #(.WIDTH_BR(4), .NUM_RAMS(NR), .MAX_BRANCHES(2), .EXPANSION_FACTOR(Z),
    .BRANCH_CFG({4'd1, 4'd0, 4'd2})) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .o_start_ready(start_ready), .i_abort(abort),
    .o_addr(addr), .o_addr_valid(valid), .i_addr_ready(ready), .o_ram_idx(ram_idx),
    .o_branch_idx(br_idx), .o_last(last), .o_busy(busy), .o_done(done));

  ldpc_ram_read_scheduler #(.WIDTH_BR(4), .NUM_RAMS(2), .MAX_BRANCHES(2), .EXPANSION_FACTOR(Z),
    .BRANCH_CFG({4'd0, 4'd1})) u_z (
    .i_clock(clk), .i_reset(rst_n), .i_start(z_start), .o_start_ready(z_sr), .i_abort(z_abort),
    .o_addr(z_addr), .o_addr_valid(z_valid), .i_addr_ready(z_ready), .o_ram_idx(z_ri),
    .o_branch_idx(z_bi), .o_last(z_last), .o_busy(z_busy), .o_done(z_done));

  always #5 clk = ~clk;

  task automatic build_model();
    ent_t e;
    q.delete();
    for (int r = 0; r < NR; r++) begin
      if (cfg[r] == 0) begin
        e = '{1'b1, r, 0, 0, 1'b0};
        q.push_back(e);
      end
      for (int b = 0; b < cfg[r]; b++)
        for (int a = 0; a < Z; a++) begin
          e = '{1'b0, r, b, a, (r == NR - 1 && b == cfg[r] - 1 && a == Z - 1)};
          q.push_back(e);
        end
    end
  endtask

  task automatic run_frame(input bit rnd, input bit hold, input int abort_idx);
    int idx = 0;
    int guard = 0;
    logic [VW-1:0] ev;
    checks++;
    if (start_ready !== 1'b1) begin failures++; $display("FAIL frame_idle start_ready got=%b exp=1", start_ready); end
    start = 1;
    @(negedge clk);
    if (!hold) start = 0;
    while (idx < q.size() && guard < 1000) begin
      guard++;
      ev = q[idx].skip ? '0 : VW'(1) << (q[idx].b * NR + q[idx].r);
      checks++;
      if (valid !== ev || busy !== 1'b1 || done !== 1'b0 || start_ready !== 1'b0) begin
        failures++;
        $display("FAIL seq[%0d] valid=%b/%b busy=%b done=%b sr=%b exp valid=%b busy=1 done=0 sr=0", idx, valid, ev, busy, done, start_ready, ev);
      end
      checks++;
      if (!q[idx].skip && (addr !== 2'(q[idx].a) || ram_idx !== 2'(q[idx].r) || br_idx !== 1'(q[idx].b) || last !== q[idx].last)) begin
        failures++;
        $display("FAIL seq_fields[%0d] addr=%0d r=%0d b=%0d last=%b exp %0d %0d %0d %b", idx, addr, ram_idx, br_idx, last, q[idx].a, q[idx].r, q[idx].b, q[idx].last);
      end else if (q[idx].skip && last !== 1'b0) begin
        failures++;
        $display("FAIL skip_last[%0d] got=%b exp=0", idx, last);
      end
      ready = rnd ? VW'($urandom) : '1;
      if (idx == abort_idx) begin
        ready = '1;
        abort = 1;
        @(negedge clk);
        abort = 0;
        checks++;
        if (valid !== '0 || busy !== 1'b0 || done !== 1'b0 || start_ready !== 1'b1) begin
          failures++;
          $display("FAIL abort valid=%b busy=%b done=%b sr=%b exp 0 0 0 1", valid, busy, done, start_ready);
        end
        return;
      end
      if (q[idx].skip || ready[q[idx].b * NR + q[idx].r]) idx++;
      @(negedge clk);
    end
    checks++;
    if (guard >= 1000) begin failures++; $display("FAIL frame_timeout got=%0d exp<%0d", guard, 1000); end
    checks++;
    if (done !== 1'b1 || valid !== '0 || busy !== 1'b1 || last !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle done=%b valid=%b busy=%b last=%b exp 1 0 1 0", done, valid, busy, last);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1 || valid !== '0) begin
      failures++;
      $display("FAIL after_done done=%b busy=%b sr=%b valid=%b exp 0 0 1 0", done, busy, start_ready, valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || valid !== '0 || addr !== '0 || last !== 1'b0) begin
      failures++;
      $display("FAIL reset sr=%b busy=%b done=%b valid=%b addr=%0d last=%b exp 1 0 0 0 0 0", start_ready, busy, done, valid, addr, last);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_full_ready();
    run_frame(1'b0, 1'b0, -1);
  endtask

  task automatic test_random_ready();
    for (int i = 0; i < 6; i++) run_frame(1'b1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, 1'b1, -1);
    run_frame(1'b1, 1'b1, -1);
    start = 0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    run_frame(1'b0, 1'b0, 2);
    run_frame(1'b0, 1'b0, -1);
    run_frame(1'b1, 1'b0, 8);
    abort = 1;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_idle sr=%b busy=%b exp 1 0", start_ready, busy); end
    start = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    checks++;
    if (busy !== 1'b1 || valid !== 6'b000001) begin failures++; $display("FAIL start_beats_abort busy=%b valid=%b exp 1 000001", busy, valid); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    run_frame(1'b1, 1'b0, -1);
  endtask

  task automatic test_async_reset();
    ready = '1;
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || valid !== '0 || addr !== '0 || last !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset sr=%b busy=%b valid=%b addr=%0d last=%b done=%b exp 1 0 0 0 0 0", start_ready, busy, valid, addr, last, done);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset sr=%b busy=%b exp 1 0", start_ready, busy); end
    run_frame(1'b0, 1'b0, -1);
  endtask

  task automatic test_last_zero();
    z_start = 1;
    @(negedge clk);
    z_start = 0;
    for (int k = 0; k < Z; k++) begin
      checks++;
      if (z_valid !== 4'b0001 || z_addr !== 2'(k) || z_last !== 1'b0 || z_done !== 1'b0) begin
        failures++;
        $display("FAIL zlast_issue[%0d] valid=%b addr=%0d last=%b done=%b exp 0001 %0d 0 0", k, z_valid, z_addr, z_last, z_done, k);
      end
      @(negedge clk);
    end
    checks++;
    if (z_valid !== 4'b0000 || z_busy !== 1'b1 || z_done !== 1'b0 || z_last !== 1'b0) begin
      failures++;
      $display("FAIL zlast_skip valid=%b busy=%b done=%b last=%b exp 0000 1 0 0", z_valid, z_busy, z_done, z_last);
    end
    @(negedge clk);
    checks++;
    if (z_done !== 1'b1 || z_valid !== 4'b0000) begin failures++; $display("FAIL zlast_done done=%b valid=%b exp 1 0000", z_done, z_valid); end
    @(negedge clk);
    checks++;
    if (z_sr !== 1'b1 || z_done !== 1'b0) begin failures++; $display("FAIL zlast_idle sr=%b done=%b exp 1 0", z_sr, z_done); end
  endtask

  initial begin
    build_model();
    repeat (2) @(negedge clk);
    test_reset();
    test_full_ready();
    test_random_ready();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_last_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ldpc_ram_read_scheduler.md
Name: ldpc_ram_read_scheduler

Overview:
Sequences the read-out of an LDPC RAM bank: NUM_RAMS columns, each built from a per-column number of branch RAMs of depth EXPANSION_FACTOR. On a start handshake it walks every column, then every branch within the column, then every address 0..EXPANSION_FACTOR-1. For each address it drives the shared read address and a one-hot valid to the selected branch RAM, honouring that RAM's ready. It sits between the decoder control FSM and the super-RAM read-address ports.

Parameters:
WIDTH_BR, 4, bits per entry of BRANCH_CFG
NUM_RAMS, 12, number of RAM columns
MAX_BRANCHES, 8, maximum branches per column; the valid/ready vector width is MAX_BRANCHES*NUM_RAMS
EXPANSION_FACTOR, 96, depth of each branch RAM (Z); must be at least 2
BRANCH_CFG, {NUM_RAMS{4'd6}}, packed branch count per column; column r occupies bits [r*WIDTH_BR +: WIDTH_BR]; each entry must be 0..MAX_BRANCHES, and any entry above MAX_BRANCHES is an elaboration error

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  start request; qualified by o_start_ready
o_start_ready  out  1  high only in IDLE
i_abort  in  1  synchronous abort of the current frame
o_addr  out  $clog2(EXPANSION_FACTOR)  shared read address
o_addr_valid  out  MAX_BRANCHES*NUM_RAMS  one-hot valid; bit index is b*NUM_RAMS+r
i_addr_ready  in  MAX_BRANCHES*NUM_RAMS  per-RAM address ready
o_ram_idx  out  $clog2(NUM_RAMS)  current column r
o_branch_idx  out  $clog2(MAX_BRANCHES)  current branch b
o_last  out  1  high with the final address of the frame
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; all counters 0; o_addr=0, o_addr_valid=0, o_last=0, o_busy=0, o_done=0, o_start_ready=1.
- States: IDLE, ISSUE, SKIP, DONE.
- IDLE -> start accepted when i_start & o_start_ready in cycle T. Load r=0, b=0, a=0.
  - If BRANCH_CFG[0]!=0: enter ISSUE at T+1.
  - Otherwise: enter SKIP at T+1.
- i_start in any other state: ignored, not queued.
- ISSUE: o_addr=a; o_addr_valid has exactly bit b*NUM_RAMS+r set.
- Transfer happens when i_addr_ready[b*NUM_RAMS+r] is high in an ISSUE cycle.
- Without a transfer: o_addr, o_addr_valid, o_ram_idx and o_branch_idx are held stable.
- On transfer:
  - a<Z-1: a++.
  - a==Z-1 and b<BRANCH_CFG[r]-1: a=0, b++.
  - Otherwise: a=0, b=0, r++. The next state is ISSUE or SKIP depending on whether the new column's count is nonzero.
  - If r was NUM_RAMS-1: go to DONE instead.
- Only the ready bit of the selected RAM is examined; all other ready bits are ignored.
- SKIP: a zero-branch column consumes exactly one cycle with o_addr_valid=0. Next state follows the same rule: next column, or DONE after the last column.
- o_last = ISSUE & r==NUM_RAMS-1 & b==BRANCH_CFG[r]-1 & a==Z-1.
  - If the last column is zero-branch, o_last is never asserted; the final SKIP leads to DONE.
- DONE: o_done=1 and o_addr_valid=0 for exactly one cycle, then IDLE.
- Throughput: one address per cycle when ready is held high. Back-to-back frames have a 2-cycle gap (DONE, then the IDLE accept cycle).
- i_abort in ISSUE, SKIP or DONE:
  - Next state is IDLE; counters are cleared; no o_done pulse.
  - o_addr_valid falls the next cycle.
  - A transfer in the abort cycle is still counted as a handshake by the RAM.
- i_abort in IDLE has no effect. i_abort and i_start together in IDLE: start wins.
- Counter widths:
  - a: $clog2(Z) bits.
  - b: $clog2(MAX_BRANCHES) bits, with a minimum of 1.
  - r: $clog2(NUM_RAMS) bits, with a minimum of 1.
  - The scheduler never wraps a counter past its configured limit.

Test Plan:
- NUM_RAMS=2, MAX_BRANCHES=2, Z=4, BRANCH_CFG={1,2}, ready all 1, start at T -> valid bit0 at T+1..T+4 (addr 0..3), bit2 at T+5..T+8, bit1 at T+9..T+12; o_last at T+12; o_done at T+13; o_start_ready at T+14.
- Same configuration with i_addr_ready[2]=0 for 3 cycles when addr=1 on bit2 -> o_addr=1 and bit2 held for 3 cycles; o_done delayed by 3 cycles to T+16; toggling other ready bits has no effect.
- BRANCH_CFG={1,0} (column 0 has zero branches) -> one SKIP cycle at T+1 with valid=0; bit1 carries addr 0..3 at T+2..T+5; o_done at T+6.
- Abort asserted during the transfer of addr=2 on bit0 -> valid=0 the next cycle; no o_done; a fresh start restarts at r=0, b=0, a=0.
- i_reset driven low mid-ISSUE, not on a clock edge -> all outputs reach reset values immediately; after release, o_start_ready=1.
- i_start held high continuously -> exactly one frame per IDLE visit; starts arriving while busy are dropped.
